// File: rtl/dm_responder_pkg.sv
// Shared types and default geometry for the data-memory responder.
// The write-mode option is selected with the DM_WRITE_FIRST_EN macro.
package dm_responder_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_DEPTH   = 128;
  localparam int DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter must be able to hold LATENCY-1; clog2(LATENCY+1) covers it with margin.
  function automatic int cnt_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_LATENCY);

endpackage

// File: rtl/dm_resp_ram.sv
// Single-port synchronous word array with a registered read port.
// DM_WRITE_FIRST_EN selects write-first; otherwise a store returns the old word.
module dm_resp_ram
  import dm_responder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;

  assign idx = addr[IDX_W-1:0];

  // The array itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en) begin
`ifdef DM_WRITE_FIRST_EN
      rdata <= we ? wdata : mem[idx];
`else
      rdata <= mem[idx];
`endif
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Fixed-latency data-memory responder for the SimpleRISC DM port.
// Store response data depends on DM_WRITE_FIRST_EN (write-first vs read-first).
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              done
);

  localparam int CNT_W = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              oob_q;
  logic              in_range;
  logic              access;
  logic [DATA_W-1:0] ram_rdata;

  assign in_range = ({1'b0, req_addr} < DEPTH_L);
  assign access   = (state == RESP);

  // The access edge is the one leaving RESP, so done and data appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      oob_q    <= 1'b0;
      req_we   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ena) begin
            req_we   <= wea;
            req_addr <= addra;
            req_data <= dina;
            cnt      <= CNT_LOAD;
            state    <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= RESP;
          end
        end
        RESP: begin
          done  <= 1'b1;
          oob_q <= ~in_range;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dm_resp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (access && in_range),
    .we    (req_we),
    .addr  (req_addr),
    .wdata (req_data),
    .rdata (ram_rdata)
  );

  // Out-of-range accesses leave the RAM register untouched and report zero instead.
  assign douta = oob_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_dm_responder.sv
// Randomized self-checking bench for dm_responder, three configurations side by side.
module tb_dm_responder;

  localparam int NU = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena   [NU];
  logic        wea   [NU];
  logic [6:0]  addra [NU];
  logic [31:0] dina  [NU];
  logic [31:0] douta [NU];
  logic        done  [NU];

  int          lat   [NU];
  int          depth [NU];
  logic [31:0] model [NU][128];
  bit          known [NU][128];
  logic [31:0] last_out   [NU];
  bit          last_known [NU];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  dm_responder #(.LATENCY(2)) u_a (
    .clk(clk), .rst(rst), .ena(ena[0]), .wea(wea[0]), .addra(addra[0]),
    .dina(dina[0]), .douta(douta[0]), .done(done[0]));

  dm_responder #(.DEPTH(100), .LATENCY(3)) u_b (
    .clk(clk), .rst(rst), .ena(ena[1]), .wea(wea[1]), .addra(addra[1]),
    .dina(dina[1]), .douta(douta[1]), .done(done[1]));

  dm_responder #(.LATENCY(1)) u_c (
    .clk(clk), .rst(rst), .ena(ena[2]), .wea(wea[2]), .addra(addra[2]),
    .dina(dina[2]), .douta(douta[2]), .done(done[2]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge of the done cycle.
  task automatic applyStimulus(input int u, input bit we, input int a,
                               input logic [31:0] d, input bit chk);
    logic [31:0] exp;
    bit          ek;
    if (a >= depth[u]) begin
      exp = 32'h0;
      ek  = 1'b1;
    end else if (!we) begin
      exp = model[u][a];
      ek  = known[u][a];
    end else begin
`ifdef DM_WRITE_FIRST_EN
      exp = d;
      ek  = 1'b1;
`else
      exp = model[u][a];
      ek  = known[u][a];
`endif
      model[u][a] = d;
      known[u][a] = 1'b1;
    end
    ena[u]   = 1'b1;
    wea[u]   = we;
    addra[u] = 7'(a);
    dina[u]  = d;
    @(posedge clk);
    for (int j = 0; j <= lat[u]; j++) begin
      @(negedge clk);
      if (j < lat[u]) begin
        checkOutput("done_early", {31'b0, done[u]}, 32'h0);
        if (last_known[u]) checkOutput("douta_hold", douta[u], last_out[u]);
        if ($urandom_range(1) == 1) begin
          ena[u]   = 1'($urandom_range(1));
          wea[u]   = 1'($urandom_range(1));
          addra[u] = 7'($urandom_range(127));
          dina[u]  = $urandom;
        end
      end else begin
        checkOutput("done", {31'b0, done[u]}, 32'h1);
        if (chk && ek) checkOutput("douta", douta[u], exp);
        last_out[u]   = exp;
        last_known[u] = ek;
        ena[u]        = 1'b0;
      end
    end
  endtask

  task automatic idleCycles(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("done_idle", {31'b0, done[u]}, 32'h0);
      if (last_known[u]) checkOutput("douta_idle", douta[u], last_out[u]);
    end
  endtask

  initial begin
    lat   = '{2, 3, 1};
    depth = '{128, 100, 128};
    for (int u = 0; u < NU; u++) begin
      ena[u] = 1'b0; wea[u] = 1'b0; addra[u] = '0; dina[u] = '0;
      last_out[u] = 32'h0; last_known[u] = 1'b1;
      for (int a = 0; a < 128; a++) known[u][a] = 1'b0;
    end

    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      checkOutput("reset_done", {31'b0, done[u]}, 32'h0);
      checkOutput("reset_douta", douta[u], 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int u = 0; u < NU; u++)
      for (int a = 0; a < depth[u]; a++)
        applyStimulus(u, 1'b1, a, $urandom, 1'b0);

    // Directed checks on the default configuration
    applyStimulus(0, 1'b1, 5, 32'hDEADBEEF, 1'b1);
    idleCycles(0, 2);
    applyStimulus(0, 1'b0, 5, 32'h0, 1'b1);
    checkOutput("load_deadbeef", last_out[0], 32'hDEADBEEF);
    applyStimulus(0, 1'b1, 9, 32'h11111111, 1'b1);
    applyStimulus(0, 1'b1, 9, 32'h22222222, 1'b1);
    applyStimulus(0, 1'b0, 0, 32'h0, 1'b1);
    applyStimulus(0, 1'b0, 1, 32'h0, 1'b1);
    idleCycles(0, 3);

    // Out-of-range behaviour on the 100-word configuration
    applyStimulus(1, 1'b1, 120, 32'hAAAA5555, 1'b1);
    applyStimulus(1, 1'b0, 120, 32'h0, 1'b1);
    idleCycles(1, 2);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1'b0, $urandom_range(99), 32'h0, 1'b1);

    // Randomized traffic on all three configurations
    for (int i = 0; i < 150; i++) begin
      for (int u = 0; u < NU; u++) begin
        applyStimulus(u, 1'($urandom_range(1)), $urandom_range(127), $urandom, 1'b1);
        idleCycles(u, $urandom_range(2));
      end
    end

    // Reset one cycle after accepting a store: the store must not commit
    ena[0] = 1'b1; wea[0] = 1'b1; addra[0] = 7'd3; dina[0] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    ena[0] = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_no_done", {31'b0, done[0]}, 32'h0);
      checkOutput("rst_douta", douta[0], 32'h0);
    end
    rst = 1'b0;
    for (int u = 0; u < NU; u++) begin
      last_out[u]   = 32'h0;
      last_known[u] = 1'b1;
    end
    idleCycles(0, 3);
    applyStimulus(0, 1'b0, 3, 32'h0, 1'b1);
    checkOutput("rst_store_dropped", last_out[0], model[0][3]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
